// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter: FSM states, read-owner codes, widths.
package dmem_arbiter_pkg;

   localparam int unsigned STARVE_MAX_DEF = 4;
   localparam int unsigned AW             = 32;
   localparam int unsigned DW             = 32;
   localparam int unsigned BW             = 4;

   typedef enum logic {
      P_OWN  = 1'b0,
      P_LOCK = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_PIPE = 2'd1,
      OWN_DMA  = 2'd2
   } owner_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates one data-memory port between the pipeline and a DMA/debug requester,
// keeping misaligned pairs together and bounding DMA starvation.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clk_en,
   input  logic          flush,
   input  logic          p_req,
   input  logic          p_split,
   input  logic [AW-1:0] p_addr,
   input  logic [DW-1:0] p_wdata,
   input  logic [BW-1:0] p_we,
   output logic          p_gnt,
   output logic          p_stall,
   output logic          p_rvalid,
   output logic [DW-1:0] p_rdata,
   input  logic          d_req,
   input  logic [AW-1:0] d_addr,
   input  logic [BW-1:0] d_we,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          m_en,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   output logic [BW-1:0] m_we,
   input  logic [DW-1:0] m_rdata
);

   localparam int unsigned   CW      = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

   state_e        r_state;
   state_e        w_state_nxt;
   logic [CW-1:0] r_starve_cnt;
   owner_e        r_owner;
   logic          r_adv;
   logic          w_active;
   logic          w_starved;
   logic          w_p_gnt;
   logic          w_d_gnt;
   logic          w_p_rd;
   logic          w_d_rd;

   assign w_active  = clk_en & ~rst;
   assign w_starved = d_req & (r_starve_cnt == CNT_MAX);

   // State register; a frozen cycle keeps the split reservation.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= P_OWN;
      end else if (clk_en) begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: the lock survives only while the pipeline keeps issuing split halves.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         P_OWN:   if (w_p_gnt && p_split) w_state_nxt = P_LOCK;
         P_LOCK:  if (!(w_p_gnt && p_split)) w_state_nxt = P_OWN;
         default: w_state_nxt = P_OWN;
      endcase
   end

   // Grant decode: locked pipeline first, then starved DMA, then pipeline, then DMA.
   always_comb begin
      w_p_gnt = 1'b0;
      w_d_gnt = 1'b0;
      if (w_active) begin
         case (r_state)
            P_LOCK: w_p_gnt = p_req & ~flush;
            default: begin
               if (w_starved) begin
                  w_d_gnt = 1'b1;
               end else if (p_req && !flush) begin
                  w_p_gnt = 1'b1;
               end else begin
                  w_d_gnt = d_req;
               end
            end
         endcase
      end
   end

   // Starvation counter and read-return owner; r_adv marks that the previous cycle advanced.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve_cnt <= '0;
         r_owner      <= OWN_NONE;
         r_adv        <= 1'b0;
      end else begin
         r_adv <= clk_en;
         if (clk_en) begin
            if (w_d_gnt || !d_req) begin
               r_starve_cnt <= '0;
            end else if (r_starve_cnt != CNT_MAX) begin
               r_starve_cnt <= r_starve_cnt + CW'(1);
            end
            if (w_p_gnt && (p_we == '0)) begin
               r_owner <= OWN_PIPE;
            end else if (w_d_gnt && (d_we == '0)) begin
               r_owner <= OWN_DMA;
            end else begin
               r_owner <= OWN_NONE;
            end
         end
      end
   end

   // Read return is steered to whoever owned last cycle's read; flush does not cancel it.
   assign w_p_rd = clk_en & r_adv & (r_owner == OWN_PIPE);
   assign w_d_rd = clk_en & r_adv & (r_owner == OWN_DMA);

   assign p_gnt    = w_p_gnt;
   assign p_stall  = p_req & ~w_p_gnt;
   assign d_gnt    = w_d_gnt;
   assign p_rvalid = w_p_rd;
   assign p_rdata  = w_p_rd ? m_rdata : '0;
   assign d_rvalid = w_d_rd;
   assign d_rdata  = w_d_rd ? m_rdata : '0;

   assign m_en    = w_p_gnt | w_d_gnt;
   assign m_addr  = w_p_gnt ? p_addr  : (w_d_gnt ? d_addr  : '0);
   assign m_wdata = w_p_gnt ? p_wdata : (w_d_gnt ? d_wdata : '0);
   assign m_we    = w_p_gnt ? p_we    : (w_d_gnt ? d_we    : '0);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a behavioural model predicts each cycle's outputs,
// a monitor on the falling edge compares them against the DUT.
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   localparam int SM = 4;

   logic        clk, rst, clk_en, flush;
   logic        p_req, p_split;
   logic [31:0] p_addr, p_wdata;
   logic [3:0]  p_we;
   logic        p_gnt, p_stall, p_rvalid;
   logic [31:0] p_rdata;
   logic        d_req;
   logic [31:0] d_addr, d_wdata;
   logic [3:0]  d_we;
   logic        d_gnt, d_rvalid;
   logic [31:0] d_rdata;
   logic        m_en;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_we;
   logic [31:0] m_rdata;

   dmem_arbiter #(.STARVE_MAX(SM)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush),
      .p_req(p_req), .p_split(p_split), .p_addr(p_addr), .p_wdata(p_wdata), .p_we(p_we),
      .p_gnt(p_gnt), .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
      .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_en(m_en), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_rdata(m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst, clk_en, flush, p_req, p_split;
      logic [31:0] p_addr, p_wdata;
      logic [3:0]  p_we;
      logic        d_req;
      logic [31:0] d_addr, d_wdata;
      logic [3:0]  d_we;
      logic [31:0] m_rdata;
   } stim_t;

   typedef struct {
      string       tag;
      logic        pg, dg, ps, men;
      logic [31:0] maddr, mwdata;
      logic [3:0]  mwe;
      logic        prv;
      logic [31:0] prd;
      logic        drv;
      logic [31:0] drd;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: split reservation, starvation count, reads awaiting return.
   bit m_lock;
   int m_cnt;
   bit m_prev_pread, m_prev_dread;

   function automatic stim_t idle();
      stim_t s;
      s = '{default: '0};
      s.clk_en = 1'b1;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s.rst     = ($urandom % 40) == 0;
      s.clk_en  = ($urandom % 8) != 0;
      s.flush   = ($urandom % 10) == 0;
      s.p_req   = ($urandom % 10) < 6;
      s.p_split = ($urandom % 4) == 0;
      s.p_addr  = $urandom;
      s.p_wdata = $urandom;
      s.p_we    = ($urandom % 2) ? 4'h0 : 4'($urandom);
      s.d_req   = ($urandom % 2) == 1;
      s.d_addr  = $urandom;
      s.d_wdata = $urandom;
      s.d_we    = ($urandom % 2) ? 4'h0 : 4'($urandom);
      s.m_rdata = $urandom;
      return s;
   endfunction

   // Apply one cycle of stimulus, predict its outputs, then advance the model at the edge.
   task automatic step(input string tag, input stim_t s);
      exp_t e;
      bit   en, pg, dg;
      rst = s.rst; clk_en = s.clk_en; flush = s.flush;
      p_req = s.p_req; p_split = s.p_split; p_addr = s.p_addr; p_wdata = s.p_wdata; p_we = s.p_we;
      d_req = s.d_req; d_addr = s.d_addr; d_wdata = s.d_wdata; d_we = s.d_we;
      m_rdata = s.m_rdata;

      en = s.clk_en && !s.rst;
      pg = 1'b0;
      dg = 1'b0;
      if (en) begin
         if (m_lock)                         pg = s.p_req && !s.flush;
         else if (s.d_req && m_cnt == SM)    dg = 1'b1;
         else if (s.p_req && !s.flush)       pg = 1'b1;
         else                                dg = s.d_req;
      end
      e.tag    = tag;
      e.pg     = pg;
      e.dg     = dg;
      e.ps     = s.p_req && !pg;
      e.men    = pg || dg;
      e.maddr  = pg ? s.p_addr  : (dg ? s.d_addr  : 32'h0);
      e.mwdata = pg ? s.p_wdata : (dg ? s.d_wdata : 32'h0);
      e.mwe    = pg ? s.p_we    : (dg ? s.d_we    : 4'h0);
      e.prv    = m_prev_pread && s.clk_en;
      e.prd    = e.prv ? s.m_rdata : 32'h0;
      e.drv    = m_prev_dread && s.clk_en;
      e.drd    = e.drv ? s.m_rdata : 32'h0;
      sb_q.push_back(e);

      @(posedge clk);
      #1;
      if (s.rst) begin
         m_lock = 0; m_cnt = 0; m_prev_pread = 0; m_prev_dread = 0;
      end else if (s.clk_en) begin
         m_lock = pg && s.p_split;
         if (dg || !s.d_req) m_cnt = 0;
         else if (m_cnt < SM) m_cnt = m_cnt + 1;
         m_prev_pread = pg && (s.p_we == 4'h0);
         m_prev_dread = dg && (s.d_we == 4'h0);
      end else begin
         m_prev_pread = 0;
         m_prev_dread = 0;
      end
   endtask

   // Monitor: one expectation per cycle, compared mid-cycle.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         bit   ok;
         e  = sb_q.pop_front();
         ok = (p_gnt === e.pg) && (d_gnt === e.dg) && (p_stall === e.ps) && (m_en === e.men) &&
              (m_addr === e.maddr) && (m_we === e.mwe) && (!e.men || m_wdata === e.mwdata) &&
              (p_rvalid === e.prv) && (p_rdata === e.prd) &&
              (d_rvalid === e.drv) && (d_rdata === e.drd);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL %s @%0t: got pg=%b dg=%b stall=%b men=%b addr=%h we=%h wd=%h prv=%b prd=%h drv=%b drd=%h | required pg=%b dg=%b stall=%b men=%b addr=%h we=%h wd=%h prv=%b prd=%h drv=%b drd=%h",
                     e.tag, $time, p_gnt, d_gnt, p_stall, m_en, m_addr, m_we, m_wdata,
                     p_rvalid, p_rdata, d_rvalid, d_rdata,
                     e.pg, e.dg, e.ps, e.men, e.maddr, e.mwe, e.mwdata, e.prv, e.prd, e.drv, e.drd);
         end
      end
   end

   initial begin
      stim_t s;
      rst = 1'b1; clk_en = 1'b0; flush = 1'b0; p_req = 1'b0; p_split = 1'b0;
      p_addr = '0; p_wdata = '0; p_we = '0; d_req = 1'b0; d_addr = '0; d_wdata = '0; d_we = '0;
      m_rdata = '0;
      m_lock = 0; m_cnt = 0; m_prev_pread = 0; m_prev_dread = 0;
      @(posedge clk);
      #1;

      s = idle(); s.rst = 1'b1;
      step("reset", s);
      step("reset", s);
      s = idle();
      step("idle", s);

      // Single pipeline read and its data return.
      s = idle(); s.p_req = 1'b1; s.p_addr = 32'h100;
      step("p_read", s);
      s = idle(); s.m_rdata = 32'hCAFE_F00D;
      step("p_rdata", s);

      // Sustained contention: pipeline four times, then starved DMA.
      s = idle(); s.p_req = 1'b1; s.p_addr = 32'h200;
      s.d_req = 1'b1; s.d_addr = 32'h300; s.d_we = 4'hF; s.d_wdata = 32'h1234_5678;
      for (int i = 0; i < 6; i++) begin
         s.m_rdata = $urandom;
         step("contend", s);
      end
      s = idle();
      step("idle", s);

      // Split store straddling the starvation limit.
      s = idle(); s.p_req = 1'b1; s.p_addr = 32'h200; s.d_req = 1'b1; s.d_addr = 32'h500;
      for (int i = 0; i < 3; i++) step("pre_split", s);
      s.p_split = 1'b1; s.p_addr = 32'h103; s.p_we = 4'b1000; s.p_wdata = 32'hAA00_0000;
      step("split1", s);
      s.p_split = 1'b0; s.p_addr = 32'h107; s.p_we = 4'b0111; s.p_wdata = 32'h00BB_CCDD;
      step("split2", s);
      s.p_we = 4'h0; s.p_addr = 32'h10C;
      step("split_after", s);
      s = idle();
      step("idle", s);

      // Flush while locked, then DMA takes the port.
      s = idle(); s.p_req = 1'b1; s.p_split = 1'b1; s.p_addr = 32'h203;
      step("lock", s);
      s.flush = 1'b1; s.d_req = 1'b1; s.d_addr = 32'h400;
      step("flush_lock", s);
      s = idle(); s.d_req = 1'b1; s.d_addr = 32'h400; s.m_rdata = 32'h0BAD_BEEF;
      step("flush_after", s);
      s = idle(); s.m_rdata = 32'h5555_AAAA;
      step("d_rdata", s);

      // Freeze mid-contention, then resume.
      s = idle(); s.p_req = 1'b1; s.p_addr = 32'h600; s.d_req = 1'b1; s.d_addr = 32'h700;
      for (int i = 0; i < 2; i++) step("pre_freeze", s);
      s.clk_en = 1'b0;
      for (int i = 0; i < 3; i++) step("freeze", s);
      s.clk_en = 1'b1;
      for (int i = 0; i < 4; i++) step("resume", s);

      // Reset in the middle of a split.
      s = idle(); s.p_req = 1'b1; s.p_split = 1'b1; s.p_addr = 32'h803; s.d_req = 1'b1;
      step("lock_pre_rst", s);
      s.rst = 1'b1;
      step("rst_in_lock", s);
      s.rst = 1'b0;
      step("post_rst", s);
      s = idle();
      step("idle", s);

      repeat (400) step("rand", rand_stim());

      repeat (3) @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
